// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and per-digit helper functions for the
// multi-digit up/down BCD counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic bcd_is_legal(input bcd_digit_t d);
    return (d <= BCD_MAX) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle between a BCD counter stage and whatever drives it.
interface bcd_updown_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      clr;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   load_val;
  logic                      cin;
  logic                      up;
  logic [4*NUM_DIGITS-1:0]   q;
  logic                      cout;
  logic                      load_err;

  modport master (
    output clr, load, load_val, cin, up,
    input  q, cout, load_err
  );

  modport slave (
    input  clr, load, load_val, cin, up,
    output q, cout, load_err
  );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register: clear, clamped load, and wrapping increment/decrement.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic       clr,
  input  bcd_digit_t d,
  output bcd_digit_t q,
  output logic       is_max,
  output logic       is_min
);

  bcd_digit_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= BCD_MIN;
    end else if (clr) begin
      r_q <= BCD_MIN;
    end else if (load) begin
      r_q <= bcd_clamp(d);
    end else if (inc) begin
      r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
    end else if (dec) begin
      r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
    end else begin
      r_q <= r_q;
    end
  end

  assign q      = r_q;
  assign is_max = (r_q == BCD_MAX);
  assign is_min = (r_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascadable NUM_DIGITS-digit BCD up/down counter with combinational carry/borrow.
// Optional BCD_UPDOWN_COUNTER_SATURATE_EN: hold at all 9s / all 0s instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input logic                clk,
  input logic                rst,
  bcd_updown_counter_if.slave bus
);

  localparam int W = 4 * NUM_DIGITS;

  logic [NUM_DIGITS-1:0] w_is_max;
  logic [NUM_DIGITS-1:0] w_is_min;
  logic [NUM_DIGITS-1:0] w_inc;
  logic [NUM_DIGITS-1:0] w_dec;
  logic [NUM_DIGITS-1:0] w_illegal;
  logic [W-1:0]          w_q;
  logic                  w_all_max;
  logic                  w_all_min;
  logic                  w_count;
  logic                  w_step_up;
  logic                  w_step_dn;
  logic                  r_load_err;

  assign w_all_max = &w_is_max;
  assign w_all_min = &w_is_min;
  assign w_count   = bus.cin & ~bus.load & ~bus.clr;

`ifdef BCD_UPDOWN_COUNTER_SATURATE_EN
  assign w_step_up = w_count &  bus.up & ~w_all_max;
  assign w_step_dn = w_count & ~bus.up & ~w_all_min;
`else
  assign w_step_up = w_count &  bus.up;
  assign w_step_dn = w_count & ~bus.up;
`endif

  // A digit steps only when every lower digit sits at its terminal value.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign w_inc[k] = w_step_up;
      assign w_dec[k] = w_step_dn;
    end else begin : g_upper
      assign w_inc[k] = w_step_up & (&w_is_max[k-1:0]);
      assign w_dec[k] = w_step_dn & (&w_is_min[k-1:0]);
    end

    assign w_illegal[k] = ~bcd_is_legal(bus.load_val[4*k +: 4]);

    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .inc    (w_inc[k]),
      .dec    (w_dec[k]),
      .load   (bus.load),
      .clr    (bus.clr),
      .d      (bus.load_val[4*k +: 4]),
      .q      (w_q[4*k +: 4]),
      .is_max (w_is_max[k]),
      .is_min (w_is_min[k])
    );
  end

  // Flags a clamped load for exactly the cycle after it; clear masks the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_err <= 1'b0;
    end else if (bus.clr) begin
      r_load_err <= 1'b0;
    end else if (bus.load) begin
      r_load_err <= |w_illegal;
    end else begin
      r_load_err <= 1'b0;
    end
  end

  // Terminal-value carry stays combinational so stages cascade without latency.
  assign bus.cout     = w_count & ~rst & (bus.up ? w_all_max : w_all_min);
  assign bus.q        = w_q;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed scoreboard bench for the 4-digit BCD up/down counter.
module tb_bcd_updown_counter;

  localparam int ND = 4;
  localparam int W  = 4 * ND;

`ifdef BCD_UPDOWN_COUNTER_SATURATE_EN
  localparam int UP_TERM = 9999;
  localparam int DN_TERM = 0;
`else
  localparam int UP_TERM = 0;
  localparam int DN_TERM = 9999;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  bcd_updown_counter_if #(.NUM_DIGITS(ND)) bus ();

  bcd_updown_counter #(.NUM_DIGITS(ND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t  sb[$];
  string tag_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    m        = 0;

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic c, input logic l,
                      input logic [W-1:0] lv, input logic ci, input logic u);
    int   nxt;
    int   d;
    logic e;
    logic exp_cout;
    exp_t x;
    string t;
    @(negedge clk);
    bus.clr = c; bus.load = l; bus.load_val = lv; bus.cin = ci; bus.up = u;
    #1;
    exp_cout = ci & ~l & ~c & (u ? (m == 9999) : (m == 0));
    chk({tag, "/cout"}, W'(bus.cout), W'(exp_cout));
    e = 1'b0;
    if (c) begin
      nxt = 0;
    end else if (l) begin
      nxt = 0;
      for (int k = ND - 1; k >= 0; k--) begin
        d = int'(lv[4*k +: 4]);
        if (d > 9) begin
          d = 9;
          e = 1'b1;
        end
        nxt = nxt * 10 + d;
      end
    end else if (ci) begin
      if (u) nxt = (m == 9999) ? UP_TERM : m + 1;
      else   nxt = (m == 0)    ? DN_TERM : m - 1;
    end else begin
      nxt = m;
    end
    sb.push_back('{q: int2bcd(nxt), err: e});
    tag_q.push_back(tag);
    m = nxt;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    t = tag_q.pop_front();
    chk({t, "/q"},   bus.q,            x.q);
    chk({t, "/err"}, W'(bus.load_err), W'(x.err));
  endtask

  initial begin
    rst = 1'b1;
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.cin = 1'b1; bus.up = 1'b0;
    #7;
    chk("reset/q",    bus.q,            '0);
    chk("reset/err",  W'(bus.load_err), '0);
    chk("reset/cout", W'(bus.cout),     '0);
    @(negedge clk);
    rst = 1'b0; bus.cin = 1'b0;

    step("ld0120", 1'b0, 1'b1, 16'h0120, 1'b0, 1'b1);
    step("up121",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    step("up122",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    step("up123",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle with a down-count request pending at zero.
    @(posedge clk);
    #2;
    bus.cin = 1'b1; bus.up = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst/q",    bus.q,            '0);
    chk("arst/err",  W'(bus.load_err), '0);
    chk("arst/cout", W'(bus.cout),     '0);
    @(negedge clk);
    rst = 1'b0; bus.cin = 1'b0;
    m = 0;
    step("resume", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    step("ld0999",   1'b0, 1'b1, 16'h0999, 1'b0, 1'b1);
    step("casc_up",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    step("ld9999c",  1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
    step("wrap_up",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    step("hold",     1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    step("ld1000",   1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    step("borrow",   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step("clr",      1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step("wrap_dn",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    step("ld_bad",   1'b0, 1'b1, 16'h3F5A, 1'b0, 1'b1);
    step("err_drop", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    step("ld0042",   1'b0, 1'b1, 16'h0042, 1'b0, 1'b1);
    step("prio",     1'b1, 1'b1, 16'h3F5A, 1'b1, 1'b1);

    step("ld0005",   1'b0, 1'b1, 16'h0005, 1'b0, 1'b1);
    step("tog_up1",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    step("tog_dn1",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step("tog_up2",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    step("tog_dn2",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    @(negedge clk);
    bus.cin = 1'b0; bus.load = 1'b0; bus.clr = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
